// File: rtl/weight_row_dispatcher_if.sv
// Handshake and row-write bundle between the weight buffer, the dispatcher and the
// systolic array's row weight registers.
interface weight_row_dispatcher_if #(
    parameter int ARRAY_SIZE      = 8,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int ROW_ADDR_WIDTH  = 3,
    parameter int NUM_WEIGHT_ROWS = 8
);
    logic                                      map_load;
    logic [NUM_WEIGHT_ROWS*ROW_ADDR_WIDTH-1:0] map_in;
    logic                                      w_valid;
    logic                                      w_ready;
    logic [ARRAY_SIZE*WEIGHT_WIDTH-1:0]        w_data;
    logic [ARRAY_SIZE-1:0]                     pe_row_we;
    logic [ARRAY_SIZE*WEIGHT_WIDTH-1:0]        pe_row_data;
    logic                                      load_done;
    logic                                      map_err;
    logic                                      busy;

    modport master (
        output map_load, map_in, w_valid, w_data,
        input  w_ready, pe_row_we, pe_row_data, load_done, map_err, busy
    );

    modport slave (
        input  map_load, map_in, w_valid, w_data,
        output w_ready, pe_row_we, pe_row_data, load_done, map_err, busy
    );
endinterface

// File: rtl/weight_row_dispatcher.sv
// Streams logical weight rows into the physical array rows named by a captured mapping table.
// Define MAP_CHECK_EN to validate the table (range and collisions) before any row is written.
module weight_row_dispatcher #(
    parameter int ARRAY_SIZE      = 8,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int ROW_ADDR_WIDTH  = 3,
    parameter int NUM_WEIGHT_ROWS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    weight_row_dispatcher_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_WEIGHT_ROWS) + 1;
    localparam int MAP_W = NUM_WEIGHT_ROWS * ROW_ADDR_WIDTH;
    localparam int ROW_W = ARRAY_SIZE * WEIGHT_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WEIGHT_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_STREAM,
        S_DONE,
        S_ERR
    } state_t;

    state_t                    state_q, state_d;
    logic [MAP_W-1:0]          table_q;
    logic [IDX_W-1:0]          idx_q;
    logic [ARRAY_SIZE-1:0]     we_q;
    logic [ROW_W-1:0]          data_q;
    logic                      done_q;

    logic [ROW_ADDR_WIDTH-1:0] entry;
    logic [ARRAY_SIZE-1:0]     entry_oh;
    logic                      last;
    logic                      accept;
    logic                      capture;
    logic                      check_pass;

    // Current table entry and its one-hot row; out-of-range entries decode to all zeros.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        entry = '0;
        for (int k = 0; k < NUM_WEIGHT_ROWS; k++) begin
            if (int'(idx_q) == k) begin
                entry = table_q[k*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH];
            end
        end
        entry_oh = '0;
        for (int r = 0; r < ARRAY_SIZE; r++) begin
            if (int'(entry) == r) begin
                entry_oh[r] = 1'b1;
            end
        end
    end

    assign last   = (idx_q == LAST_IDX);
    assign accept = (state_q == S_STREAM) && bus.w_valid;

`ifdef MAP_CHECK_EN
    logic [ARRAY_SIZE-1:0] used_q;
    logic                  entry_bad;

    assign entry_bad  = (entry_oh == '0) || ((entry_oh & used_q) != '0);
    assign check_pass = (state_q == S_CHECK) && !entry_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q <= '0;
        end else if (capture) begin
            used_q <= '0;
        end else if (check_pass) begin
            used_q <= used_q | entry_oh;
        end
    end
`else
    assign check_pass = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.map_load) begin
                    capture = 1'b1;
`ifdef MAP_CHECK_EN
                    state_d = S_CHECK;
`else
                    state_d = S_STREAM;
`endif
                end
            end
`ifdef MAP_CHECK_EN
            S_CHECK: begin
                if (entry_bad) begin
                    state_d = S_ERR;
                end else if (last) begin
                    state_d = S_STREAM;
                end
            end
            S_ERR: begin
                if (bus.map_load) begin
                    capture = 1'b1;
                    state_d = S_CHECK;
                end
            end
`endif
            S_STREAM: begin
                if (accept && last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the mapping table is a handful of flops, so it is reset like any other state.
            table_q <= '0;
            idx_q   <= '0;
        end else if (capture) begin
            table_q <= bus.map_in;
            idx_q   <= '0;
        end else if (check_pass) begin
            idx_q <= last ? '0 : idx_q + IDX_W'(1);
        end else if (accept) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    // One-cycle write strobe after each accept; load_done trails the DONE state by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            we_q   <= accept ? entry_oh : '0;
            done_q <= (state_q == S_DONE);
            if (accept) begin
                data_q <= bus.w_data;
            end
        end
    end

    assign bus.w_ready     = (state_q == S_STREAM);
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_ERR);
    assign bus.pe_row_we   = we_q;
    assign bus.pe_row_data = data_q;
    assign bus.load_done   = done_q;
`ifdef MAP_CHECK_EN
    assign bus.map_err     = (state_q == S_ERR);
`else
    assign bus.map_err     = 1'b0;
`endif
endmodule
